// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and offset sign-extension for prog_sequencer
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Sign-extends the low w bits of v to 32 bits; callers truncate to PC width.
  function automatic logic [31:0] sext32(input logic [31:0] v, input int w);
    logic [31:0] hi_mask;
    hi_mask = 32'hFFFF_FFFF << w;
    if (((v >> (w - 1)) & 32'd1) != 32'd0) return v | hi_mask;
    return v & ~hi_mask;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - return-address LIFO; only the pointer is reset, entries are don't-care
module ret_stack #(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] push_data_i,
  output logic [PC_W-1:0] top_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [SP_W-1:0] sp_q, sp_d;
  logic [PC_W-1:0] mem_q [STACK_DEPTH];
  logic            do_push, do_pop;

  assign full_o  = (sp_q == SP_W'(STACK_DEPTH));
  assign empty_o = (sp_q == '0);
  assign do_push = push_i && !full_o && !clr_i;
  assign do_pop  = pop_i && !empty_o && !clr_i;
  assign top_o   = empty_o ? '0 : mem_q[IDX_W'(sp_q - SP_W'(1))];

  always_comb begin
    sp_d = sp_q;
    if (clr_i)        sp_d = '0;
    else if (do_push) sp_d = sp_q + SP_W'(1);
    else if (do_pop)  sp_d = sp_q - SP_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sp_q <= '0;
    else         sp_q <= sp_d;
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[IDX_W'(sp_q)] <= push_data_i;
  end

endmodule

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - PC, run handshake, relative branch/call/return and run-cycle counter
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W        = 10,
  parameter int BOFF_W      = 6,
  parameter int STACK_DEPTH = 4,
  parameter int START_ADDR  = 0,
  parameter int CNT_W       = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stall,
  input  logic              Halt,
  input  logic              Jen,
  input  logic              Call,
  input  logic              Ret,
  input  logic [BOFF_W-1:0] BImmed,
  output logic [PC_W-1:0]   PC,
  output logic              Busy,
  output logic              Done,
  output logic              StackErr,
  output logic [CNT_W-1:0]  CycCnt
);

  seq_state_t       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             push, pop, clr;
  logic [PC_W-1:0]  pc_inc, pc_tgt, top;
  logic             full, empty;

  assign pc_inc = pc_q + PC_W'(1);
  assign pc_tgt = pc_q + PC_W'(sext32(32'(BImmed), BOFF_W));

  ret_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk_i       (Clk),
    .rst_ni      (Reset),
    .clr_i       (clr),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (pc_inc),
    .top_o       (top),
    .full_o      (full),
    .empty_o     (empty)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    push    = 1'b0;
    pop     = 1'b0;
    clr     = 1'b0;
    case (state_q)
      RUN: begin
        // The cycle that leaves RUN is still counted.
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        if (Stall) begin
          pc_d = pc_q;
        end else if (Halt) begin
          state_d = DONE;
        end else if (Ret) begin
          if (empty) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            pc_d = top;
            pop  = 1'b1;
          end
        end else if (Call) begin
          if (full) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            push = 1'b1;
            pc_d = pc_tgt;
          end
        end else if (Jen) begin
          pc_d = pc_tgt;
        end else begin
          pc_d = pc_inc;
        end
      end
      default: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = PC_W'(START_ADDR);
          cnt_d   = '0;
          err_d   = 1'b0;
          clr     = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= PC_W'(START_ADDR);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign PC       = pc_q;
  assign Busy     = (state_q == RUN);
  assign Done     = (state_q == DONE);
  assign StackErr = err_q;
  assign CycCnt   = cnt_q;

endmodule
